// File: rtl/mix_col_sequencer.sv
// mix_col_sequencer: column-serial AES MixColumns/InvMixColumns engine (one 32-bit column per cycle)
// Ports: i_clk, i_rst_n (async active-low); i_valid/o_ready + i_enc_dec/i_state accept a 128-bit state;
// o_valid/i_ready present o_state; i_flush aborts to IDLE; o_busy is high in BUSY or DONE.
// Optional macro MIXCOL_LAST_ROUND_BYPASS_EN adds i_bypass: accepted state goes straight to DONE unmixed.
module mix_invmix_col (
  input  logic [31:0] col,
  input  logic        enc_dec,
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  logic [7:0] u, v, p0, p1, p2, p3;
  // InvMixColumns = MixColumns applied after a {04,00,05,00}-style preconditioning step
  always_comb begin
    u = enc_dec ? 8'h00 : xt(xt(col[31:24] ^ col[15:8]));
    v = enc_dec ? 8'h00 : xt(xt(col[23:16] ^ col[7:0]));
    p0 = col[31:24] ^ u;
    p1 = col[23:16] ^ v;
    p2 = col[15:8] ^ u;
    p3 = col[7:0] ^ v;
    res = {xt(p0 ^ p1) ^ p1 ^ p2 ^ p3, xt(p1 ^ p2) ^ p2 ^ p3 ^ p0,
           xt(p2 ^ p3) ^ p3 ^ p0 ^ p1, xt(p3 ^ p0) ^ p0 ^ p1 ^ p2};
  end
endmodule

module mix_col_sequencer #(
  parameter int NUM_COLS = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_enc_dec,
  input  logic [127:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state,
  output logic         o_busy
`ifdef MIXCOL_LAST_ROUND_BYPASS_EN
  ,
  input  logic         i_bypass
`endif
);
  if (NUM_COLS != 4) begin : g_bad_num_cols
    $error("mix_col_sequencer: NUM_COLS must be 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st, nxt;
  logic [1:0] col_cnt;
  logic [3:0][31:0] in_cols, out_cols;
  logic enc_dec, accept, bypass;
  logic [31:0] col_res;
`ifdef MIXCOL_LAST_ROUND_BYPASS_EN
  assign bypass = i_bypass;
`else
  assign bypass = 1'b0;
`endif
  assign accept = (st == IDLE) && i_valid && !i_flush;
  assign o_ready = (st == IDLE);
  assign o_valid = (st == DONE);
  assign o_busy = (st != IDLE);
  assign o_state = out_cols;
  // column 0 sits in the MSBs, so packed index 3 - col_cnt == ~col_cnt
  mix_invmix_col u_col (.col(in_cols[~col_cnt]), .enc_dec(enc_dec), .res(col_res));
  always_comb begin
    nxt = st;
    if (i_flush) nxt = IDLE;
    else if (accept) nxt = bypass ? DONE : BUSY;
    else if (st == BUSY && col_cnt == 2'd3) nxt = DONE;
    else if (st == DONE && i_ready) nxt = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt <= 2'd0;
      in_cols <= '0;
      enc_dec <= 1'b0;
      out_cols <= '0;
    end else begin
      col_cnt <= (st == BUSY && !i_flush) ? col_cnt + 2'd1 : 2'd0;
      if (accept) begin
        in_cols <= i_state;
        enc_dec <= i_enc_dec;
      end
      if (accept && bypass) out_cols <= i_state;
      if (st == BUSY && !i_flush) out_cols[~col_cnt] <= col_res;
    end
  end
endmodule

// File: tb/tb_mix_col_sequencer.sv
// tb_mix_col_sequencer: directed self-checking bench for mix_col_sequencer
module tb_mix_col_sequencer;
  logic i_clk = 0, i_rst_n = 1, i_flush = 0, i_valid = 0, i_enc_dec = 0, i_ready = 1;
  logic [127:0] i_state = '0;
  logic o_ready, o_valid, o_busy;
  logic [127:0] o_state;
`ifdef MIXCOL_LAST_ROUND_BYPASS_EN
  logic i_bypass = 0;
`endif
  int checks = 0, failures = 0;
  typedef struct {
    string        name;
    logic         enc;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[6];
  localparam logic [127:0] V_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_C = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V_D = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  mix_col_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_enc_dec(i_enc_dec), .i_state(i_state), .o_valid(o_valid),
    .i_ready(i_ready), .o_state(o_state), .o_busy(o_busy)
`ifdef MIXCOL_LAST_ROUND_BYPASS_EN
    , .i_bypass(i_bypass)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_vec(input string name, input logic enc, input logic [127:0] st,
                         input logic [127:0] exp);
    int lat;
    @(negedge i_clk);
    i_valid = 1;
    i_enc_dec = enc;
    i_state = st;
    @(posedge i_clk);
    #1;
    i_valid = 0;
    i_enc_dec = ~enc;
    i_state = '0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, 4);
    check({name, " state"}, o_state, exp);
    @(posedge i_clk);
    #1;
    check({name, " back_to_idle"}, o_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    int n;
    vecs[0] = '{"enc_a", 1'b1, V_A, V_B};
    vecs[1] = '{"dec_a", 1'b0, V_B, V_A};
    vecs[2] = '{"enc_fips", 1'b1, V_C, V_D};
    vecs[3] = '{"dec_fips", 1'b0, V_D, V_C};
    vecs[4] = '{"enc_zero", 1'b1, 128'h0, 128'h0};
    vecs[5] = '{"dec_ones", 1'b0, {128{1'b1}}, {128{1'b1}}};
    #2 i_rst_n = 0;
    #1;
    check("rst o_ready", o_ready, 1);
    check("rst o_valid", o_valid, 0);
    check("rst o_busy", o_busy, 0);
    check("rst o_state", o_state, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i].name, vecs[i].enc, vecs[i].st, vecs[i].exp);
    // back-pressure in DONE while input side toggles
    i_ready = 0;
    @(negedge i_clk);
    i_valid = 1;
    i_enc_dec = 1;
    i_state = V_A;
    @(posedge i_clk);
    #1;
    i_valid = 0;
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("bp latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_enc_dec = ~i_enc_dec;
      i_valid = 1;
      i_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge i_clk);
      #1;
      check("bp hold state", o_state, V_B);
      check("bp o_ready", o_ready, 0);
      check("bp o_valid", o_valid, 1);
    end
    @(negedge i_clk);
    i_valid = 0;
    i_ready = 1;
    @(posedge i_clk);
    #1;
    check("bp release o_ready", o_ready, 1);
    check("bp release o_valid", o_valid, 0);
    // flush after column 1 has been written
    @(negedge i_clk);
    i_valid = 1;
    i_enc_dec = 1;
    i_state = V_A;
    @(posedge i_clk);
    #1;
    i_valid = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_flush = 1;
    i_valid = 1;
    @(posedge i_clk);
    #1;
    check("flush o_ready", o_ready, 1);
    check("flush o_busy", o_busy, 0);
    @(posedge i_clk);
    #1;
    check("flush blocks accept", o_ready, 1);
    i_flush = 0;
    i_valid = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      seen |= o_valid;
    end
    check("flush no o_valid", seen, 0);
    run_vec("enc_after_flush", 1'b1, V_A, V_B);
    // asynchronous reset in mid-period while BUSY
    @(negedge i_clk);
    i_valid = 1;
    i_enc_dec = 1;
    i_state = V_C;
    @(posedge i_clk);
    #1;
    i_valid = 0;
    @(posedge i_clk);
    #3;
    i_rst_n = 0;
    #1;
    check("arst o_valid", o_valid, 0);
    check("arst o_ready", o_ready, 1);
    check("arst o_busy", o_busy, 0);
    check("arst o_state", o_state, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    run_vec("enc_after_rst", 1'b1, V_C, V_D);
`ifdef MIXCOL_LAST_ROUND_BYPASS_EN
    @(negedge i_clk);
    i_valid = 1;
    i_bypass = 1;
    i_state = 128'h00112233_44556677_8899aabb_ccddeeff;
    @(posedge i_clk);
    #1;
    i_valid = 0;
    i_bypass = 0;
    i_state = '0;
    check("bypass o_valid", o_valid, 1);
    check("bypass state", o_state, 128'h00112233_44556677_8899aabb_ccddeeff);
    @(posedge i_clk);
    #1;
    check("bypass back_to_idle", o_ready, 1);
    run_vec("enc_no_bypass", 1'b1, V_A, V_B);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mix_col_sequencer.md
Name: mix_col_sequencer

Overview:
- Column-serial MixColumns / InvMixColumns engine for the AES round pipeline.
- Accepts a 128-bit state and pushes it one 32-bit column per cycle through a single shared `mix_invmix_col` datapath instance.
- Assembles the four result columns and presents the 128-bit state on a valid/ready output.
- Trades about 4x datapath area for 4 cycles of latency; sits between ShiftRows and AddRoundKey in the iterative core.

Parameters:
- NUM_COLS, 4, number of columns per state. Fixed to 4 for AES; any other value is a compile-time error.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  synchronous abort; returns the block to IDLE
- i_valid  input  1  input state valid
- o_ready  output  1  block can accept input
- i_enc_dec  input  1  1 = MixColumns, 0 = InvMixColumns; sampled at accept
- i_state  input  128  input state; column c = bits [127-32c -: 32], row 0 in the MSB byte
- o_valid  output  1  output state valid
- i_ready  input  1  downstream accepts output
- o_state  output  128  result state, same packing as i_state
- o_busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (i_rst_n low, asynchronous): state = IDLE; col_cnt = 0; o_state = 0; o_valid = 0; o_ready = 1; o_busy = 0; internal input and mode registers = 0.
- o_ready = (state == IDLE). o_valid = (state == DONE). Both are registered-state decodes, with no combinational path from i_valid or i_ready.
- IDLE:
  - On i_valid & o_ready: latch i_state, latch i_enc_dec, set col_cnt = 0, go to BUSY.
- BUSY:
  - Each cycle, feed column col_cnt of the latched state to the datapath. Datapath byte [3] = row 0 (column MSB byte), byte [0] = row 3.
  - Write the datapath result into o_state column col_cnt at the clock edge, then col_cnt++.
  - When col_cnt == 3 at an edge, go to DONE (col_cnt wraps to 0).
- DONE:
  - Hold o_state stable while o_valid & !i_ready; back-pressure can last indefinitely.
  - On i_ready, go to IDLE at that edge.
- Latency: accept at edge E0, column k written at edge E(k+1), o_valid high after E4. Minimum initiation interval is 6 cycles when i_ready is held high.
- Mode: the latched enc_dec governs all 4 columns. Changes on i_enc_dec after accept are ignored.
- i_flush:
  - Highest priority, over any handshake in the same cycle.
  - Next state = IDLE, col_cnt = 0, o_valid drops at the next edge.
  - o_state contents are left as-is (don't-care).
  - i_valid is not accepted in a flush cycle.
- i_valid while BUSY or DONE: ignored, no accept. The upstream must hold its data.
- Reset asserted mid-operation: immediate return to reset values; any partial result is discarded.
- o_state columns not yet written in BUSY may hold stale data. o_state is only meaningful while o_valid is high.

Optional Feature:
- Macro: MIXCOL_LAST_ROUND_BYPASS_EN
- Defined:
  - Adds port i_bypass (input, 1 bit), sampled at accept.
  - If i_bypass = 1, the block goes IDLE -> DONE directly and o_state = i_state, with o_valid high after E1. This serves the AES final round, which has no MixColumns.
  - If i_bypass = 0, behaviour is as above.
- Undefined:
  - Port i_bypass is absent; every accepted state takes the 4-cycle BUSY path.

Test Plan:
- Encrypt: i_enc_dec = 1, i_state = db135345_f20a225c_01010101_c6c6c6c6 -> o_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with o_valid rising exactly 4 edges after accept.
- Decrypt: i_enc_dec = 0, i_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> o_state = db135345_f20a225c_01010101_c6c6c6c6.
- Back-pressure and mode change:
  - Hold i_ready = 0 for 10 cycles in DONE and toggle i_enc_dec / i_valid meanwhile -> o_state stable, o_ready = 0, no second accept.
  - Raise i_ready -> IDLE next cycle, o_ready = 1.
- Flush mid-BUSY: assert i_flush after column 1 is written -> o_valid never asserts, state = IDLE next cycle. A following encrypt of the vector from the first scenario yields the correct result.
- Async reset: pulse i_rst_n low in the middle of a clock period during BUSY -> o_valid = 0, o_ready = 1, o_state = 0 immediately, without waiting for a clock edge.
- MIXCOL_LAST_ROUND_BYPASS_EN defined: i_bypass = 1 with state 00112233_44556677_8899aabb_ccddeeff -> identical o_state, o_valid after 1 edge. With i_bypass = 0, the first scenario's result is unchanged.
